// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// noc_pkg : address field widths and stall-monitor state type for the NoC
// Revision: 1.0
// ============================================================================
package noc_pkg;

  localparam int GRP_W  = 4;
  localparam int LEAF_W = 2;
  localparam int ADDR_W = GRP_W + LEAF_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    STALLED = 2'd2
  } stall_state_e;

endpackage
`default_nettype wire

// File: rtl/gpu_ingress_buffer_if.sv
`default_nettype none
// ============================================================================
// gpu_ingress_buffer_if : GPU request handshake plus router-facing flit bus
// Revision: 1.0
// ============================================================================
interface gpu_ingress_buffer_if
  import noc_pkg::*;
#(
  parameter int DWIDTH = 16
);

  logic [DWIDTH-1:0] gpu_req_data;
  logic [ADDR_W-1:0] gpu_req_dest;
  logic              gpu_req_valid;
  logic              gpu_req_ready;
  logic [DWIDTH-1:0] rtr_data;
  logic [ADDR_W-1:0] rtr_dest;
  logic              rtr_valid;
  logic              rtr_accept;

  // slave: the ingress buffer itself
  modport slave (
    input  gpu_req_data, gpu_req_dest, gpu_req_valid, rtr_accept,
    output gpu_req_ready, rtr_data, rtr_dest, rtr_valid
  );

  // master: the GPU/router environment around the buffer
  modport master (
    output gpu_req_data, gpu_req_dest, gpu_req_valid, rtr_accept,
    input  gpu_req_ready, rtr_data, rtr_dest, rtr_valid
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock show-ahead FIFO with occupancy count
// Revision: 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       wr_en,
  input  wire logic [WIDTH-1:0]           wr_data,
  input  wire logic                       rd_en,
  output logic      [WIDTH-1:0]           rd_data,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/gpu_ingress_buffer.sv
`default_nettype none
// ============================================================================
// gpu_ingress_buffer : GPU-to-router ingress FIFO with self-address drop,
// traffic counters and head-of-line stall monitor
// Revision: 1.0
// ============================================================================
module gpu_ingress_buffer
  import noc_pkg::*;
#(
  parameter int              DWIDTH      = 16,
  parameter int              FIFO_DEPTH  = 8,
  parameter logic [GRP_W-1:0] GROUP_ID   = 4'b0101,
  parameter int              ROUTER_ID   = 3,
  parameter int              STALL_LIMIT = 64
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  gpu_ingress_buffer_if.slave                bus,
  output logic                               fifo_full,
  output logic                               fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
  output logic [15:0]                        sent_cnt,
  output logic [7:0]                         drop_cnt,
  output logic                               stall
);

  localparam int                CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] c_self      = {GROUP_ID, LEAF_W'(ROUTER_ID)};
  localparam logic [7:0]        c_wait_last = 8'(STALL_LIMIT - 1);

  logic [DWIDTH+ADDR_W-1:0] w_head;
  logic                     w_xfer;
  logic                     w_self;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_empty_next;
  logic [15:0]              r_sent_cnt;
  logic [7:0]               r_drop_cnt;
  logic [7:0]               r_wait_cnt;
  logic [7:0]               w_wait_next;
  stall_state_e             r_state;
  stall_state_e             w_state_next;

  assign bus.gpu_req_ready = !fifo_full && !reset;
  assign w_xfer            = bus.gpu_req_valid && bus.gpu_req_ready;
  assign w_self            = (bus.gpu_req_dest == c_self);
  assign w_push            = w_xfer && !w_self;
  assign w_pop             = !fifo_empty && bus.rtr_accept;

  sync_fifo #(
    .WIDTH (DWIDTH + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_push),
    .wr_data ({bus.gpu_req_dest, bus.gpu_req_data}),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Storage is not reset, so the head is masked while empty
  assign bus.rtr_valid = !fifo_empty;
  assign bus.rtr_data  = fifo_empty ? '0 : w_head[DWIDTH-1:0];
  assign bus.rtr_dest  = fifo_empty ? '0 : w_head[DWIDTH+ADDR_W-1:DWIDTH];

  assign w_empty_next = ((fifo_count == '0) && !w_push) ||
                        ((fifo_count == CW'(1)) && w_pop && !w_push);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sent_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop) r_sent_cnt <= r_sent_cnt + 16'd1;
      if (w_xfer && w_self && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  // Entering WAIT on the push edge makes the first presented cycle count
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    case (r_state)
      IDLE: begin
        w_wait_next = '0;
        if (w_push) w_state_next = WAIT;
      end
      WAIT: begin
        if (w_pop) begin
          w_wait_next  = '0;
          w_state_next = w_empty_next ? IDLE : WAIT;
        end else if (r_wait_cnt == c_wait_last) begin
          w_state_next = STALLED;
        end else begin
          w_wait_next = r_wait_cnt + 8'd1;
        end
      end
      STALLED: begin
        if (w_pop) begin
          w_wait_next  = '0;
          w_state_next = w_empty_next ? IDLE : WAIT;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_wait_next  = '0;
      end
    endcase
  end

  assign sent_cnt = r_sent_cnt;
  assign drop_cnt = r_drop_cnt;
  assign stall    = (r_state == STALLED);

endmodule
`default_nettype wire

// File: tb/tb_gpu_ingress_buffer.sv
`default_nettype none
// ============================================================================
// tb_gpu_ingress_buffer : directed and random stimulus against a queue model
// Revision: 1.0
// ============================================================================
module tb_gpu_ingress_buffer;

  localparam int         DW    = 16;
  localparam int         DEPTH = 8;
  localparam int         LIMIT = 64;
  localparam logic [5:0] SELF  = 6'b010111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_full, fifo_empty, stall;
  logic [3:0]  fifo_count;
  logic [15:0] sent_cnt;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  gpu_ingress_buffer_if #(.DWIDTH(DW)) bus ();

  gpu_ingress_buffer #(
    .DWIDTH(DW), .FIFO_DEPTH(DEPTH), .GROUP_ID(4'b0101), .ROUTER_ID(3), .STALL_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [21:0] m_q[$];
  logic [15:0] m_sent = '0;
  int          m_drop = 0;
  int          m_head_wait = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_sent      = '0;
      m_drop      = 0;
      m_head_wait = 0;
      chk_en      = 1'b1;
    end else begin
      bit take;
      take = bus.gpu_req_valid && (m_q.size() < DEPTH);
      if (m_q.size() > 0 && bus.rtr_accept) begin
        void'(m_q.pop_front());
        m_sent++;
        m_head_wait = 0;
      end else if (m_q.size() > 0 && m_head_wait < 1000) begin
        m_head_wait++;
      end
      if (take) begin
        if (bus.gpu_req_dest == SELF) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_q.push_back({bus.gpu_req_dest, bus.gpu_req_data});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [21:0] hd;
      hd = (m_q.size() > 0) ? m_q[0] : 22'd0;
      chk("ready", 32'(bus.gpu_req_ready), 32'((m_q.size() < DEPTH) && !reset));
      chk("rtr_valid", 32'(bus.rtr_valid), 32'(m_q.size() > 0));
      chk("rtr_data", 32'(bus.rtr_data), 32'(hd[15:0]));
      chk("rtr_dest", 32'(bus.rtr_dest), 32'(hd[21:16]));
      chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
      chk("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
      chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      chk("sent_cnt", 32'(sent_cnt), 32'(m_sent));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("stall", 32'(stall), 32'(m_head_wait >= LIMIT));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic offer(input logic v, input logic [5:0] d, input logic [15:0] x);
    bus.gpu_req_valid = v;
    bus.gpu_req_dest  = d;
    bus.gpu_req_data  = x;
  endtask

  initial begin
    offer(1'b0, 6'd0, 16'd0);
    bus.rtr_accept = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // single flit passes through
    offer(1'b1, 6'b000001, 16'hA5A5);
    bus.rtr_accept = 1'b1;
    tick();
    offer(1'b0, 6'd0, 16'd0);
    chk("t1_valid", 32'(bus.rtr_valid), 32'd1);
    chk("t1_data", 32'(bus.rtr_data), 32'hA5A5);
    chk("t1_dest", 32'(bus.rtr_dest), 32'h01);
    tick();
    chk("t1_sent", 32'(sent_cnt), 32'd1);
    chk("t1_empty", 32'(fifo_empty), 32'd1);

    // fill to full, 9th offer blocked then taken after a pop
    bus.rtr_accept = 1'b0;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 6'(i + 8), 16'(16'h0100 + i));
      tick();
    end
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_ready", 32'(bus.gpu_req_ready), 32'd0);
    chk("fill_count", 32'(fifo_count), 32'd8);
    offer(1'b1, 6'd33, 16'h01FF);
    tick();
    tick();
    chk("fill_9th_blocked", 32'(fifo_count), 32'd8);
    bus.rtr_accept = 1'b1;
    tick();
    tick();
    offer(1'b0, 6'd0, 16'd0);
    repeat (10) tick();
    chk("fill_drained", 32'(sent_cnt), 32'd10);

    // self-addressed drops and saturation
    do_reset();
    bus.rtr_accept = 1'b0;
    offer(1'b1, SELF, 16'h1234);
    repeat (3) tick();
    chk("drop3", 32'(drop_cnt), 32'd3);
    chk("drop_empty", 32'(fifo_empty), 32'd1);
    chk("drop_ready", 32'(bus.gpu_req_ready), 32'd1);
    repeat (260) tick();
    offer(1'b0, 6'd0, 16'd0);
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // head-of-line stall, twice with a restart in between
    do_reset();
    bus.rtr_accept = 1'b0;
    offer(1'b1, 6'd2, 16'hBEEF);
    tick();
    offer(1'b1, 6'd3, 16'hCAFE);
    tick();
    offer(1'b0, 6'd0, 16'd0);
    repeat (62) tick();
    chk("stall_pre", 32'(stall), 32'd0);
    tick();
    chk("stall_rise", 32'(stall), 32'd1);
    bus.rtr_accept = 1'b1;
    tick();
    bus.rtr_accept = 1'b0;
    chk("stall_fall", 32'(stall), 32'd0);
    repeat (63) tick();
    chk("stall2_pre", 32'(stall), 32'd0);
    tick();
    chk("stall2_rise", 32'(stall), 32'd1);
    bus.rtr_accept = 1'b1;
    repeat (2) tick();

    // streaming push and pop every cycle
    do_reset();
    bus.rtr_accept = 1'b1;
    for (int i = 0; i < 100; i++) begin
      offer(1'b1, 6'(i % 20), 16'(i * 7 + 3));
      tick();
      if (i == 50) chk("stream_count", 32'(fifo_count), 32'd1);
    end
    offer(1'b0, 6'd0, 16'd0);
    tick();
    chk("stream_sent", 32'(sent_cnt), 32'd100);

    // reset mid-stream
    bus.rtr_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 6'd4, 16'(i));
      tick();
    end
    offer(1'b0, 6'd0, 16'd0);
    reset = 1'b1;
    #1;
    chk("rst_ready_low", 32'(bus.gpu_req_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.rtr_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_sent", 32'(sent_cnt), 32'd0);
    chk("rst_ready_high", 32'(bus.gpu_req_ready), 32'd1);

    // random traffic with varying back-pressure
    begin
      int acc_pct = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 200 == 0) acc_pct = $urandom_range(0, 100);
        offer($urandom_range(0, 3) != 0,
              ($urandom_range(0, 7) == 0) ? SELF : 6'($urandom),
              16'($urandom));
        bus.rtr_accept = ($urandom_range(0, 99) < acc_pct);
        reset = ($urandom_range(0, 599) == 0);
        tick();
      end
      reset = 1'b0;
      offer(1'b0, 6'd0, 16'd0);
      bus.rtr_accept = 1'b1;
      repeat (12) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
